// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - ROM fetch and ALU operand/result bundle for alu_sequencer
interface alu_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_y;

    // Sequencer side: drives the ROM address and ALU operands, samples ROM word and ALU result.
    modport master (
        output rom_addr,
        output alu_a,
        output alu_b,
        output alu_op,
        input  rom_data,
        input  alu_y
    );

    // ROM/ALU side.
    modport slave (
        input  rom_addr,
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output rom_data,
        output alu_y
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - program-driven initiator fetching 8-bit instructions and driving a 4-bit ALU
module alu_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    alu_sequencer_if.master   bus,
    output logic [DATA_W-1:0] acc,
    output logic              zero,
    output logic              busy,
    output logic              done
);
    localparam logic [7:0] HALT_WORD = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_op;
    logic              r_wb;
    logic              r_zero;
    logic              r_busy;
    logic              r_done;

    logic              w_halt;
    logic              w_pc_last;
    logic              w_y_zero;

    // The ROM is registered, so presenting pc directly keeps the address stable through FETCH.
    assign bus.rom_addr = r_pc;
    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_op   = r_alu_op;

    assign acc  = r_acc;
    assign zero = r_zero;
    assign busy = r_busy;
    assign done = r_done;

    // Decode helpers: HALT detection, last-address detection (no wrap), ALU zero flag.
    assign w_halt    = (bus.rom_data == HALT_WORD);
    assign w_pc_last = (r_pc == {ADDR_W{1'b1}});
    assign w_y_zero  = (bus.alu_y == {DATA_W{1'b0}});

    // Sequencer FSM: fetch, decode, execute, write back, with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_acc    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_wb     <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_acc   <= '0;
                        r_zero  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_halt) begin
                        // HALT never reaches the ALU; operands keep their previous values.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wb     <= bus.rom_data[7];
                        r_alu_a  <= r_acc;
                        r_alu_b  <= bus.rom_data[DATA_W-1:0];
                        r_alu_op <= bus.rom_data[6:4];
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_wb) begin
                        r_acc <= bus.alu_y;
                    end
                    r_zero  <= w_y_zero;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_pc_last) begin
                        // Running off the end of the address space ends the program.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_pc    <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
